udp_roce_conn_meta_tx_64: RTL and testbench

Transmit side of the RoCE connection-manager UDP control channel. It packs QP info and TX metadata into the fixed 36-byte metadata payload and emits it as one UDP frame: a UDP/IP header on the header interface, then five 64-bit AXIS payload beats. It sits ahead of the UDP/IP TX stack, and its frames are parsed by the peer's metadata receiver, so the byte layout must match bit for bit.

---
 rtl/udp_roce_conn_meta_tx_64.sv | 183 ++++++++++++++++++
 tb/tb_udp_roce_conn_meta_tx_64.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_roce_conn_meta_tx_64.sv
// RoCE connection-manager metadata transmitter: one UDP header plus five 64-bit payload beats per request.
// Optional packet counter output is enabled by defining CONN_META_TX_PKT_CNT_EN.
module udp_roce_conn_meta_tx_64 #(
    parameter logic [15:0] LOCAL_UDP_PORT = 16'h4321,
    parameter logic [15:0] DEST_UDP_PORT  = 16'h4321,
    parameter logic [7:0]  IP_TTL         = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_send_valid,
    output logic        s_send_ready,
    input  logic        s_qp_info_valid,
    input  logic [23:0] s_rem_qpn,
    input  logic [23:0] s_loc_qpn,
    input  logic [23:0] s_rem_psn,
    input  logic [23:0] s_loc_psn,
    input  logic [31:0] s_r_key,
    input  logic        s_txmeta_valid,
    input  logic        s_txmeta_start,
    input  logic        s_txmeta_write_type,
    input  logic [31:0] s_rem_ip_addr,
    input  logic [63:0] s_rem_addr,
    input  logic [31:0] s_dma_length,
    input  logic [15:0] s_rem_udp_port,
    input  logic [31:0] s_loc_ip_addr,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [7:0]  m_ip_ttl,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [63:0] m_udp_payload_axis_tdata,
    output logic [7:0]  m_udp_payload_axis_tkeep,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        busy
`ifdef CONN_META_TX_PKT_CNT_EN
    ,
    output logic [31:0] tx_pkt_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t       state_reg;
    logic [287:0] frame_reg;
    logic [287:0] frame_in;
    logic [287:0] frame_be;
    logic [2:0]   beat_cnt_reg;
    logic [2:0]   beat_next;
    logic [31:0]  src_ip_reg;
    logic [31:0]  dst_ip_reg;
    logic         hdr_valid_reg;
    logic         tvalid_reg;
    logic         tlast_reg;
    logic [7:0]   tkeep_reg;
    logic [63:0]  tdata_reg;

    // Wire-order byte string: most significant byte of frame_be is payload byte 0.
    assign frame_be = {7'b0, s_qp_info_valid, s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn,
                       s_r_key, 5'b0, s_txmeta_write_type, s_txmeta_start, s_txmeta_valid,
                       s_rem_ip_addr, s_rem_addr, s_dma_length, s_rem_udp_port};

    // Payload byte N lives at frame_in[8N+7:8N] so each beat is a plain 64-bit slice.
    generate
        for (genvar gi = 0; gi < 36; gi++) begin : g_byte_swap
            assign frame_in[8*gi +: 8] = frame_be[287-8*gi -: 8];
        end
    endgenerate

    function automatic logic [63:0] beat_word(input logic [287:0] f, input logic [2:0] idx);
        case (idx)
            3'd0:    beat_word = f[63:0];
            3'd1:    beat_word = f[127:64];
            3'd2:    beat_word = f[191:128];
            3'd3:    beat_word = f[255:192];
            3'd4:    beat_word = {32'h0, f[287:256]};
            default: beat_word = 64'h0;
        endcase
    endfunction

    assign beat_next = beat_cnt_reg + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_reg     <= '0;
            beat_cnt_reg  <= '0;
            src_ip_reg    <= '0;
            dst_ip_reg    <= '0;
            hdr_valid_reg <= 1'b0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tkeep_reg     <= 8'h00;
            tdata_reg     <= 64'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s_send_valid) begin
                        frame_reg     <= frame_in;
                        src_ip_reg    <= s_loc_ip_addr;
                        dst_ip_reg    <= s_rem_ip_addr;
                        hdr_valid_reg <= 1'b1;
                        state_reg     <= HDR;
                    end
                end
                HDR: begin
                    if (m_udp_hdr_ready) begin
                        hdr_valid_reg <= 1'b0;
                        tvalid_reg    <= 1'b1;
                        tdata_reg     <= beat_word(frame_reg, 3'd0);
                        tkeep_reg     <= 8'hFF;
                        tlast_reg     <= 1'b0;
                        beat_cnt_reg  <= 3'd0;
                        state_reg     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (m_udp_payload_axis_tready) begin
                        if (beat_cnt_reg == 3'd4) begin
                            tvalid_reg   <= 1'b0;
                            tlast_reg    <= 1'b0;
                            tkeep_reg    <= 8'h00;
                            tdata_reg    <= 64'h0;
                            beat_cnt_reg <= 3'd0;
                            state_reg    <= IDLE;
                        end else begin
                            beat_cnt_reg <= beat_next;
                            tdata_reg    <= beat_word(frame_reg, beat_next);
                            tkeep_reg    <= (beat_next == 3'd4) ? 8'h0F : 8'hFF;
                            tlast_reg    <= (beat_next == 3'd4);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CONN_META_TX_PKT_CNT_EN
    logic [31:0] pkt_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_reg <= '0;
        end else if (tvalid_reg && m_udp_payload_axis_tready && tlast_reg) begin
            pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
        end
    end

    assign tx_pkt_count = pkt_cnt_reg;
`endif

    assign s_send_ready              = (state_reg == IDLE) && !rst;
    assign busy                      = (state_reg != IDLE);
    assign m_udp_hdr_valid           = hdr_valid_reg;
    assign m_ip_dscp                 = 6'd0;
    assign m_ip_ecn                  = 2'd0;
    assign m_ip_ttl                  = IP_TTL;
    assign m_ip_source_ip            = src_ip_reg;
    assign m_ip_dest_ip              = dst_ip_reg;
    assign m_udp_source_port         = LOCAL_UDP_PORT;
    assign m_udp_dest_port           = DEST_UDP_PORT;
    assign m_udp_length              = 16'd44;
    assign m_udp_checksum            = 16'd0;
    assign m_udp_payload_axis_tdata  = tdata_reg;
    assign m_udp_payload_axis_tkeep  = tkeep_reg;
    assign m_udp_payload_axis_tvalid = tvalid_reg;
    assign m_udp_payload_axis_tlast  = tlast_reg;
    assign m_udp_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_udp_roce_conn_meta_tx_64.sv
// Bench for udp_roce_conn_meta_tx_64: random frames checked against a byte-level payload model.
// Define CONN_META_TX_PKT_CNT_EN to also exercise the packet counter.
module tb_udp_roce_conn_meta_tx_64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_send_valid = 1'b0;
    logic        s_send_ready;
    logic        s_qp_info_valid = 1'b0;
    logic [23:0] s_rem_qpn = '0;
    logic [23:0] s_loc_qpn = '0;
    logic [23:0] s_rem_psn = '0;
    logic [23:0] s_loc_psn = '0;
    logic [31:0] s_r_key = '0;
    logic        s_txmeta_valid = 1'b0;
    logic        s_txmeta_start = 1'b0;
    logic        s_txmeta_write_type = 1'b0;
    logic [31:0] s_rem_ip_addr = '0;
    logic [63:0] s_rem_addr = '0;
    logic [31:0] s_dma_length = '0;
    logic [15:0] s_rem_udp_port = '0;
    logic [31:0] s_loc_ip_addr = '0;
    logic        m_udp_hdr_valid;
    logic        m_udp_hdr_ready = 1'b0;
    logic [5:0]  m_ip_dscp;
    logic [1:0]  m_ip_ecn;
    logic [7:0]  m_ip_ttl;
    logic [31:0] m_ip_source_ip;
    logic [31:0] m_ip_dest_ip;
    logic [15:0] m_udp_source_port;
    logic [15:0] m_udp_dest_port;
    logic [15:0] m_udp_length;
    logic [15:0] m_udp_checksum;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        tuser;
    logic        busy;
`ifdef CONN_META_TX_PKT_CNT_EN
    logic [31:0] tx_pkt_count;
`endif

    udp_roce_conn_meta_tx_64 dut (
        .clk(clk), .rst(rst),
        .s_send_valid(s_send_valid), .s_send_ready(s_send_ready),
        .s_qp_info_valid(s_qp_info_valid), .s_rem_qpn(s_rem_qpn), .s_loc_qpn(s_loc_qpn),
        .s_rem_psn(s_rem_psn), .s_loc_psn(s_loc_psn), .s_r_key(s_r_key),
        .s_txmeta_valid(s_txmeta_valid), .s_txmeta_start(s_txmeta_start),
        .s_txmeta_write_type(s_txmeta_write_type), .s_rem_ip_addr(s_rem_ip_addr),
        .s_rem_addr(s_rem_addr), .s_dma_length(s_dma_length), .s_rem_udp_port(s_rem_udp_port),
        .s_loc_ip_addr(s_loc_ip_addr),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
        .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
        .m_udp_payload_axis_tdata(tdata), .m_udp_payload_axis_tkeep(tkeep),
        .m_udp_payload_axis_tvalid(tvalid), .m_udp_payload_axis_tready(tready),
        .m_udp_payload_axis_tlast(tlast), .m_udp_payload_axis_tuser(tuser),
        .busy(busy)
`ifdef CONN_META_TX_PKT_CNT_EN
        , .tx_pkt_count(tx_pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the 36 payload bytes in wire order, built from the field table.
    logic [7:0]  exp_bytes [36];
    logic [31:0] exp_src_ip;
    logic [31:0] exp_dst_ip;

    // Results captured by run_frame.
    logic [63:0] cap_data [$];
    logic [7:0]  cap_keep [$];
    logic        cap_last [$];
    int          hdr_unstable, tvalid_in_hdr, ready_in_hdr, hdr_in_payload, payload_unstable;
    int          tuser_seen, timeouts;
    logic        hdr_first_valid, post_ready, post_busy;
    logic [31:0] hdr_src, hdr_dst;

    function automatic void put_field(input int off, input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) exp_bytes[off+k] = 8'(v >> (8*(n-1-k)));
    endfunction

    task automatic build_expected();
        exp_bytes[0] = {7'b0, s_qp_info_valid};
        put_field(1, 64'(s_rem_qpn), 3);
        put_field(4, 64'(s_loc_qpn), 3);
        put_field(7, 64'(s_rem_psn), 3);
        put_field(10, 64'(s_loc_psn), 3);
        put_field(13, 64'(s_r_key), 4);
        exp_bytes[17] = {5'b0, s_txmeta_write_type, s_txmeta_start, s_txmeta_valid};
        put_field(18, 64'(s_rem_ip_addr), 4);
        put_field(22, s_rem_addr, 8);
        put_field(30, 64'(s_dma_length), 4);
        put_field(34, 64'(s_rem_udp_port), 2);
        exp_src_ip = s_loc_ip_addr;
        exp_dst_ip = s_rem_ip_addr;
    endtask

    function automatic logic [63:0] exp_beat(input int b);
        logic [63:0] d = '0;
        for (int j = 0; j < 8; j++)
            if (8*b + j < 36) d[8*j +: 8] = exp_bytes[8*b + j];
        return d;
    endfunction

    task automatic randomize_inputs();
        s_qp_info_valid     = 1'($urandom_range(0, 1));
        s_rem_qpn           = 24'($urandom);
        s_loc_qpn           = 24'($urandom);
        s_rem_psn           = 24'($urandom);
        s_loc_psn           = 24'($urandom);
        s_r_key             = $urandom;
        s_txmeta_valid      = 1'($urandom_range(0, 1));
        s_txmeta_start      = 1'($urandom_range(0, 1));
        s_txmeta_write_type = 1'($urandom_range(0, 1));
        s_rem_ip_addr       = $urandom;
        s_rem_addr          = {$urandom, $urandom};
        s_dma_length        = $urandom;
        s_rem_udp_port      = 16'($urandom);
        s_loc_ip_addr       = $urandom;
    endtask

    // Drives one request through header and payload; bp_mode 0 = always ready, 1 = alternate, 2 = random.
    task automatic run_frame(input int hdr_hold, input int bp_mode, input bit change_after);
        int guard;
        bit done;
        bit pend;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        cap_data.delete(); cap_keep.delete(); cap_last.delete();
        hdr_unstable = 0; tvalid_in_hdr = 0; ready_in_hdr = 0; hdr_in_payload = 0;
        payload_unstable = 0; tuser_seen = 0;
        @(negedge clk);
        s_send_valid = 1'b1;
        guard = 0;
        while (!s_send_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            timeouts++;
            s_send_valid = 1'b0;
            return;
        end
        build_expected();
        @(negedge clk);
        s_send_valid = 1'b0;
        if (change_after) s_rem_qpn = 24'h000000;
        hdr_first_valid = m_udp_hdr_valid;
        hdr_src = m_ip_source_ip;
        hdr_dst = m_ip_dest_ip;
        for (int i = 0; i < hdr_hold; i++) begin
            if (tvalid) tvalid_in_hdr++;
            if (s_send_ready) ready_in_hdr++;
            if (!m_udp_hdr_valid || m_ip_source_ip !== hdr_src || m_ip_dest_ip !== hdr_dst)
                hdr_unstable++;
            @(negedge clk);
        end
        m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        m_udp_hdr_ready = 1'b0;
        guard = 0; done = 0; pend = 0;
        pd = '0; pk = '0; pl = 1'b0;
        while (!done && guard < 100) begin
            if (m_udp_hdr_valid) hdr_in_payload++;
            if (tuser) tuser_seen++;
            case (bp_mode)
                0:       tready = 1'b1;
                1:       tready = 1'(guard % 2);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (pend && (!tvalid || tdata !== pd || tkeep !== pk || tlast !== pl))
                payload_unstable++;
            if (tvalid && tready) begin
                cap_data.push_back(tdata);
                cap_keep.push_back(tkeep);
                cap_last.push_back(tlast);
                if (tlast) done = 1;
                pend = 0;
            end else if (tvalid) begin
                pend = 1; pd = tdata; pk = tkeep; pl = tlast;
            end
            @(negedge clk);
            guard++;
        end
        tready = 1'b0;
        if (!done) timeouts++;
        post_ready = s_send_ready;
        post_busy = busy;
        $display("frame: beats=%0d hdr_hold=%0d bp_mode=%0d src=%08h dst=%08h",
                 cap_data.size(), hdr_hold, bp_mode, hdr_src, hdr_dst);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_udp_hdr_valid, tvalid, tlast, busy, s_send_ready} !== 5'b0 || tkeep !== 8'h00 || tdata !== 64'h0)
            $display("FAIL reset_state: hv=%b tv=%b tl=%b busy=%b rdy=%b keep=%h data=%h, required all zero",
                     m_udp_hdr_valid, tvalid, tlast, busy, s_send_ready, tkeep, tdata);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_send_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", s_send_ready);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [63:0] beat0_ref = 64'h00EFCDAB56341201;
        logic [63:0] beat4_ref = 64'h00000000B7120010;
        s_qp_info_valid = 1; s_rem_qpn = 24'h123456; s_loc_qpn = 24'hABCDEF;
        s_rem_psn = 24'h000001; s_loc_psn = 24'h000100; s_r_key = 32'hDEADBEEF;
        s_txmeta_valid = 1; s_txmeta_start = 1; s_txmeta_write_type = 0;
        s_rem_ip_addr = 32'h0A000001; s_rem_addr = 64'h0011223344556677;
        s_dma_length = 32'h00001000; s_rem_udp_port = 16'd4791; s_loc_ip_addr = 32'h0A000002;
        run_frame(0, 0, 0);
        n_checks++;
        if (m_udp_length !== 16'd44 || m_udp_source_port !== 16'h4321 || m_udp_dest_port !== 16'h4321 ||
            m_ip_ttl !== 8'd64 || m_udp_checksum !== 16'd0 || m_ip_dscp !== 6'd0 || m_ip_ecn !== 2'd0)
            $display("FAIL header_consts: len=%0d sp=%h dp=%h ttl=%0d csum=%h dscp=%0d ecn=%0d, required 44/4321/4321/64/0/0/0",
                     m_udp_length, m_udp_source_port, m_udp_dest_port, m_ip_ttl, m_udp_checksum, m_ip_dscp, m_ip_ecn);
        else n_pass++;
        n_checks++;
        if (hdr_first_valid !== 1'b1 || hdr_src !== 32'h0A000002 || hdr_dst !== 32'h0A000001)
            $display("FAIL header_ips: valid=%b src=%h dst=%h, required 1/0a000002/0a000001", hdr_first_valid, hdr_src, hdr_dst);
        else n_pass++;
        n_checks++;
        if (cap_data.size() != 5) $display("FAIL single_beat_count: got %0d, required 5", cap_data.size());
        else n_pass++;
        if (cap_data.size() == 5) begin
            n_checks++;
            if (cap_data[0] !== beat0_ref) $display("FAIL single_beat0: got %h, required %h", cap_data[0], beat0_ref);
            else n_pass++;
            n_checks++;
            if (cap_data[4] !== beat4_ref || cap_keep[4] !== 8'h0F)
                $display("FAIL single_beat4: got %h keep %h, required %h keep 0f", cap_data[4], cap_keep[4], beat4_ref);
            else n_pass++;
            for (int b = 0; b < 5; b++) begin
                n_checks++;
                if (cap_data[b] !== exp_beat(b) || cap_keep[b] !== ((b == 4) ? 8'h0F : 8'hFF) || cap_last[b] !== (b == 4))
                    $display("FAIL single_beat%0d: got %h/%h/%b, required %h/%h/%b", b, cap_data[b], cap_keep[b],
                             cap_last[b], exp_beat(b), (b == 4) ? 8'h0F : 8'hFF, b == 4);
                else n_pass++;
            end
        end
        n_checks++;
        if (post_ready !== 1'b1 || post_busy !== 1'b0 || tuser_seen != 0)
            $display("FAIL single_return_idle: ready=%b busy=%b tuser=%0d, required 1/0/0", post_ready, post_busy, tuser_seen);
        else n_pass++;
    endtask

    task automatic test_hdr_backpressure();
        randomize_inputs();
        run_frame(10, 0, 0);
        n_checks++;
        if (hdr_unstable != 0 || tvalid_in_hdr != 0 || ready_in_hdr != 0 || hdr_first_valid !== 1'b1)
            $display("FAIL hdr_backpressure: unstable=%0d tvalid=%0d ready=%0d first=%b, required 0/0/0/1",
                     hdr_unstable, tvalid_in_hdr, ready_in_hdr, hdr_first_valid);
        else n_pass++;
        n_checks++;
        if (hdr_src !== exp_src_ip || hdr_dst !== exp_dst_ip)
            $display("FAIL hdr_bp_ips: got %h/%h, required %h/%h", hdr_src, hdr_dst, exp_src_ip, exp_dst_ip);
        else n_pass++;
    endtask

    task automatic test_payload_backpressure();
        int lasts;
        randomize_inputs();
        run_frame(0, 1, 0);
        lasts = 0;
        n_checks++;
        if (cap_data.size() != 5 || payload_unstable != 0 || hdr_in_payload != 0)
            $display("FAIL payload_bp: beats=%0d unstable=%0d hdr_in_payload=%0d, required 5/0/0",
                     cap_data.size(), payload_unstable, hdr_in_payload);
        else n_pass++;
        for (int b = 0; b < cap_data.size() && b < 5; b++) begin
            if (cap_last[b]) lasts++;
            n_checks++;
            if (cap_data[b] !== exp_beat(b)) $display("FAIL payload_bp_beat%0d: got %h, required %h", b, cap_data[b], exp_beat(b));
            else n_pass++;
        end
        n_checks++;
        if (lasts != 1 || cap_last[cap_last.size()-1] !== 1'b1) $display("FAIL payload_bp_tlast: got %0d lasts, required 1 on beat 4", lasts);
        else n_pass++;
    endtask

    task automatic test_input_change();
        randomize_inputs();
        s_rem_qpn = 24'h123456;
        run_frame(2, 0, 1);
        n_checks++;
        if (cap_data.size() != 5 || cap_data[0][31:8] !== 24'h563412)
            $display("FAIL input_change_qpn: got %h, required rem_qpn bytes 12 34 56", cap_data.size() ? cap_data[0] : 64'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int guard, got;
        randomize_inputs();
        @(negedge clk);
        s_send_valid = 1'b1;
        guard = 0;
        while (!s_send_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        s_send_valid = 1'b0;
        m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        m_udp_hdr_ready = 1'b0;
        tready = 1'b1;
        got = 0; guard = 0;
        while (got < 3 && guard < 50) begin
            if (tvalid) got++;
            if (got < 3) @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (got != 3 || {m_udp_hdr_valid, tvalid, tlast, busy, s_send_ready} !== 5'b0)
            $display("FAIL reset_mid_frame: beats=%0d hv=%b tv=%b tl=%b busy=%b rdy=%b, required 3 and all zero",
                     got, m_udp_hdr_valid, tvalid, tlast, busy, s_send_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tready = 1'b0;
        randomize_inputs();
        run_frame(0, 0, 0);
        n_checks++;
        if (cap_data.size() != 5) $display("FAIL post_reset_count: got %0d, required 5", cap_data.size());
        else n_pass++;
        for (int b = 0; b < cap_data.size() && b < 5; b++) begin
            n_checks++;
            if (cap_data[b] !== exp_beat(b)) $display("FAIL post_reset_beat%0d: got %h, required %h", b, cap_data[b], exp_beat(b));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++) begin
            randomize_inputs();
            run_frame($urandom_range(0, 3), (f < 2) ? 0 : 2, 0);
            n_checks++;
            if (cap_data.size() != 5 || payload_unstable != 0 || hdr_in_payload != 0 || tvalid_in_hdr != 0)
                $display("FAIL rand%0d_protocol: beats=%0d unstable=%0d hip=%0d tih=%0d, required 5/0/0/0",
                         f, cap_data.size(), payload_unstable, hdr_in_payload, tvalid_in_hdr);
            else n_pass++;
            n_checks++;
            if (hdr_src !== exp_src_ip || hdr_dst !== exp_dst_ip)
                $display("FAIL rand%0d_ips: got %h/%h, required %h/%h", f, hdr_src, hdr_dst, exp_src_ip, exp_dst_ip);
            else n_pass++;
            for (int b = 0; b < cap_data.size() && b < 5; b++) begin
                n_checks++;
                if (cap_data[b] !== exp_beat(b) || cap_keep[b] !== ((b == 4) ? 8'h0F : 8'hFF) || cap_last[b] !== (b == 4))
                    $display("FAIL rand%0d_beat%0d: got %h/%h/%b, required %h", f, b, cap_data[b], cap_keep[b], cap_last[b], exp_beat(b));
                else n_pass++;
            end
        end
    endtask

`ifdef CONN_META_TX_PKT_CNT_EN
    task automatic test_pkt_count();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int f = 0; f < 3; f++) begin randomize_inputs(); run_frame(0, 2, 0); end
        n_checks++;
        if (tx_pkt_count !== 32'd3) $display("FAIL pkt_count_3: got %0d, required 3", tx_pkt_count);
        else n_pass++;
        force dut.pkt_cnt_reg = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.pkt_cnt_reg;
        randomize_inputs();
        run_frame(0, 0, 0);
        n_checks++;
        if (tx_pkt_count !== 32'd0) $display("FAIL pkt_count_wrap: got %h, required 0", tx_pkt_count);
        else n_pass++;
    endtask
`endif

    initial begin
        timeouts = 0;
        test_reset();
        test_single_frame();
        test_hdr_backpressure();
        test_payload_backpressure();
        test_input_change();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef CONN_META_TX_PKT_CNT_EN
        test_pkt_count();
`endif
        n_checks++;
        if (timeouts != 0) $display("FAIL handshake_timeouts: got %0d, required 0", timeouts);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
